dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Two-port arbiter/sequencer in front of the word-organised data memory. Shares it between the
//  core load/store port (c_*) and the DMA/loader port (d_*), one transaction in flight.
//  Converts dmctrl-coded B/H/W/BU/HU requests into byte-enabled word accesses, extends load data,
//  flags misaligned, illegal and out-of-range requests.
// PARAMETERS
//  MEM_WORDS  1024  memory depth in 32-bit words; AW = $clog2(MEM_WORDS)
//  RR         1     1: round-robin arbitration; 0: fixed priority, core always wins
// PORTS
//  clk           in   1   clock, all logic rising-edge
//  rst_n         in   1   asynchronous active-low reset
//  {c,d}_req_valid  in   1   request valid (c_ = core, d_ = DMA; one line covers both ports)
//  {c,d}_req_ready  out  1   request accepted this cycle when valid&ready
//  {c,d}_req_we     in   1   1 store, 0 load
//  {c,d}_req_ctrl   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU
//  {c,d}_req_addr   in   32  byte address
//  {c,d}_req_wdata  in   32  store data, low-aligned
//  {c,d}_rsp_valid  out  1   one-cycle response pulse; no backpressure
//  {c,d}_rsp_rdata  out  32  extended load data; 0 for stores and errors
//  {c,d}_rsp_err    out  1   request rejected, memory untouched
//  mem_en        out  1   memory access strobe
//  mem_we        out  1   write strobe (qualified by mem_en)
//  mem_be        out  4   byte enables
//  mem_addr      out  AW  word address = addr[AW+1:2]
//  mem_wdata     out  32  lane-replicated write data
//  mem_rdata     in   32  read data, valid the cycle after mem_en&!mem_we
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, RR pointer favours core. Reset mid-transaction drops it, no rsp.
//  FSM IDLE -> ACCESS -> (load) WAIT -> RESP -> IDLE; error: IDLE -> RESP.
//  IDLE: ready high only for the grant winner, combinationally; other ready 0. Accepted request
//   latched with owner id. ready 0 in all other states.
//  Arbitration: single requester wins. Both valid: RR=1 -> port not granted last; RR=0 -> core.
//  ACCESS: mem_en=1, mem_we=we, be/addr/wdata driven from latched request (one cycle only).
//  WAIT: capture mem_rdata, select lane, extend.
//  RESP: owner rsp_valid=1 for exactly one cycle, with rdata/err. Non-owner rsp outputs stay 0.
//  Latency from handshake edge to rsp_valid: store 2 cycles, load 3, error 1.
//  Lanes: B/BU be=4'b0001<<a[1:0], wdata={4{b}}. H/HU be=4'b0011<<{a[1],1'b0}, wdata={2{h}}.
//   W be=4'b1111.
//  Load extend: B/H sign-extend from bit 7/15 of selected lane; BU/HU zero-extend.
//  Errors (checked at accept, memory untouched):
//   - ctrl 011/110/111;
//   - store with BU/HU;
//   - H/HU with a[0]=1, W with a[1:0]!=0;
//   - a >= 4*MEM_WORDS.
//  rsp outputs other than during the RESP pulse: 0.
// STRUCTURE
//  dmem_pkg: dmctrl_e (LS_B, LS_H, LS_W, LS_BU, LS_HU), arb_state_e, owner_e {OWN_CORE, OWN_DMA}.
//  Sub-module dmem_lane_align: combinational ctrl+addr -> be/wdata replication, rdata lane
//   select/extend, misalign/illegal flags.
// TESTING
//  1. Core SW a=0x10 wd=0xDEADBEEF, then LW a=0x10
//     -> mem_be=1111 at word 4; load rsp_rdata=0xDEADBEEF 3 cycles after accept.
//  2. Core SB a=0x13 wd=0x80 -> be=1000, wdata=0x80808080; LB a=0x13 -> 0xFFFFFF80;
//     LBU -> 0x00000080.
//  3. SH a=0x22 wd=0x1234 -> be=1100; LH a=0x21 -> rsp_err=1 after 1 cycle, mem_en never high.
//  4. Both valid every cycle, RR=1 -> grants alternate core, dma, core...; RR=0 -> core only,
//     d_req_ready stays 0.
//  5. ctrl=011, store ctrl=100, a=0x1000 (MEM_WORDS=1024) -> each rsp_err=1, rdata=0, no mem_en.
//  6. rst_n low during WAIT of DMA load -> outputs 0 async, no d_rsp_valid;
//     next core request serviced normally.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
//   dmctrl_e    : load/store size and extension codes carried on *_req_ctrl
//   arb_state_e : transaction sequencer states
//   owner_e     : which port owns the transaction in flight
package dmem_pkg;

    typedef enum logic [2:0] {
        LS_B  = 3'b000,
        LS_H  = 3'b001,
        LS_W  = 3'b010,
        LS_BU = 3'b100,
        LS_HU = 3'b101
    } dmctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESP
    } arb_state_e;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane alignment for one load/store request.
//   ctrl, we, addr_lo : request size/extension code, direction, byte offset in word
//   wdata             : low-aligned store data
//   rdata             : raw memory word
//   be, wdata_rep     : byte enables and lane-replicated store data
//   rdata_ext         : selected lane, sign- or zero-extended
//   misalign, illegal : offset not a multiple of the access size / bad ctrl code
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic        we,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        be        = 4'b0000;
        wdata_rep = 32'h0;
        rdata_ext = 32'h0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (ctrl)
            LS_B, LS_BU: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = (ctrl == LS_B) ? {{24{lane_b[7]}}, lane_b} : {24'h0, lane_b};
                illegal   = we && (ctrl == LS_BU);
            end
            LS_H, LS_HU: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = (ctrl == LS_H) ? {{16{lane_h[15]}}, lane_h} : {16'h0, lane_h};
                misalign  = addr_lo[0];
                illegal   = we && (ctrl == LS_HU);
            end
            LS_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
                misalign  = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a word-organised data memory.
// One transaction in flight; the core (c_*) and DMA (d_*) ports share it.
//   c_req_* / d_req_*  : valid/ready request channel (we, ctrl, byte addr, wdata)
//   c_rsp_* / d_rsp_*  : one-cycle response pulse with extended rdata and error flag
//   mem_*              : single-cycle access strobe, byte enables, word address, data;
//                        mem_rdata is valid the cycle after a read strobe
// Bad requests (illegal ctrl, misaligned, out of range) skip the memory and
// answer with rsp_err one cycle after acceptance.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter bit RR        = 1'b1,
    localparam int AW       = $clog2(MEM_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          c_req_valid,
    output logic          c_req_ready,
    input  logic          c_req_we,
    input  logic [2:0]    c_req_ctrl,
    input  logic [31:0]   c_req_addr,
    input  logic [31:0]   c_req_wdata,
    output logic          c_rsp_valid,
    output logic [31:0]   c_rsp_rdata,
    output logic          c_rsp_err,
    input  logic          d_req_valid,
    output logic          d_req_ready,
    input  logic          d_req_we,
    input  logic [2:0]    d_req_ctrl,
    input  logic [31:0]   d_req_addr,
    input  logic [31:0]   d_req_wdata,
    output logic          d_rsp_valid,
    output logic [31:0]   d_rsp_rdata,
    output logic          d_rsp_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) << 2;

    arb_state_e      state, state_next;
    owner_e          owner_q, last_grant_q;
    logic            we_q, err_q;
    logic [2:0]      ctrl_q;
    logic [AW+1:0]   addr_q;
    logic [31:0]     wdata_q, rdata_q;

    logic            c_win, d_win, accept;
    logic            sel_we;
    logic [2:0]      sel_ctrl;
    logic [31:0]     sel_addr, sel_wdata;
    logic            req_err, out_of_range;

    logic            la_we;
    logic [2:0]      la_ctrl;
    logic [1:0]      la_addr_lo;
    logic [31:0]     la_wdata;
    logic [3:0]      la_be;
    logic [31:0]     la_wdata_rep, la_rdata_ext;
    logic            la_misalign, la_illegal;

    // With both ports valid, round-robin hands the grant to the port that was
    // not served last; the pointer resets to "DMA last" so the core goes first.
    always_comb begin
        c_win = 1'b0;
        d_win = 1'b0;
        if (state == ST_IDLE) begin
            c_win = c_req_valid && (!d_req_valid || !RR || last_grant_q == OWN_DMA);
            d_win = d_req_valid && !c_win;
        end
    end

    assign accept    = c_win || d_win;
    assign sel_we    = d_win ? d_req_we    : c_req_we;
    assign sel_ctrl  = d_win ? d_req_ctrl  : c_req_ctrl;
    assign sel_addr  = d_win ? d_req_addr  : c_req_addr;
    assign sel_wdata = d_win ? d_req_wdata : c_req_wdata;

    // One aligner serves both phases: in IDLE it classifies the incoming
    // request, afterwards it works on the latched one (lanes in ACCESS,
    // load extension in WAIT).
    assign la_we      = (state == ST_IDLE) ? sel_we         : we_q;
    assign la_ctrl    = (state == ST_IDLE) ? sel_ctrl       : ctrl_q;
    assign la_addr_lo = (state == ST_IDLE) ? sel_addr[1:0]  : addr_q[1:0];
    assign la_wdata   = (state == ST_IDLE) ? sel_wdata      : wdata_q;

    dmem_lane_align u_align (
        .ctrl      (la_ctrl),
        .we        (la_we),
        .addr_lo   (la_addr_lo),
        .wdata     (la_wdata),
        .rdata     (mem_rdata),
        .be        (la_be),
        .wdata_rep (la_wdata_rep),
        .rdata_ext (la_rdata_ext),
        .misalign  (la_misalign),
        .illegal   (la_illegal)
    );

    assign out_of_range = {2'b00, sel_addr} >= ADDR_LIMIT;
    assign req_err      = la_misalign || la_illegal || out_of_range;

    always_comb begin
        state_next  = state;
        c_req_ready = 1'b0;
        d_req_ready = 1'b0;
        c_rsp_valid = 1'b0;
        c_rsp_rdata = 32'h0;
        c_rsp_err   = 1'b0;
        d_rsp_valid = 1'b0;
        d_rsp_rdata = 32'h0;
        d_rsp_err   = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_be      = 4'b0000;
        mem_addr    = '0;
        mem_wdata   = 32'h0;
        case (state)
            ST_IDLE: begin
                c_req_ready = c_win;
                d_req_ready = d_win;
                if (accept) state_next = req_err ? ST_RESP : ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_en     = 1'b1;
                mem_we     = we_q;
                mem_be     = la_be;
                mem_addr   = addr_q[AW+1:2];
                mem_wdata  = la_wdata_rep;
                state_next = we_q ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: state_next = ST_RESP;
            ST_RESP: begin
                if (owner_q == OWN_CORE) begin
                    c_rsp_valid = 1'b1;
                    c_rsp_rdata = rdata_q;
                    c_rsp_err   = err_q;
                end else begin
                    d_rsp_valid = 1'b1;
                    d_rsp_rdata = rdata_q;
                    d_rsp_err   = err_q;
                end
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            owner_q      <= OWN_CORE;
            last_grant_q <= OWN_DMA;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            ctrl_q       <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            rdata_q      <= 32'h0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_next;
            if (accept) begin
                owner_q      <= d_win ? OWN_DMA : OWN_CORE;
                last_grant_q <= d_win ? OWN_DMA : OWN_CORE;
                we_q         <= sel_we;
                err_q        <= req_err;
                ctrl_q       <= sel_ctrl;
                addr_q       <= sel_addr[AW+1:0];
                wdata_q      <= sel_wdata;
                rdata_q      <= 32'h0;
            end
            if (state == ST_WAIT) rdata_q <= la_rdata_ext;
        end
    end

endmodule
